piso_mux_serializer: RTL and testbench
======================================

Name: piso_mux_serializer

Overview:
- Parallel-in, serial-out stage feeding a WIDTH:1 bit-select mux. It accepts a WIDTH-bit word on a valid/ready handshake and latches it.
- An internal select counter then walks the word one bit per accepted output beat.
- It produces the select code for the mux and sits directly upstream of the serial-bit consumers in the combinational-circuits area.

Parameters:
- WIDTH, 8, word width in bits; must be a power of 2 and at least 2.
- SEL_W, $clog2(WIDTH), select/counter width; derived, do not override.
- MSB_FIRST, 0, 0 = emit bit 0 first (sel counts up); 1 = emit bit WIDTH-1 first (sel counts down).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  parallel word; sampled only on in_valid && in_ready.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream accepts out_bit this cycle.
- out_bit  output  1  currently selected bit, equal to word_q[sel].
- out_sel  output  SEL_W  current select code.
- out_last  output  1  high when the current beat is the final bit of the word.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset values, applied asynchronously on rst=1: state=IDLE, word_q=0, sel=0 (MSB_FIRST=0) or WIDTH-1 (MSB_FIRST=1), out_valid=0, out_last=0, busy=0, in_ready=1.
- States:
  - IDLE: out_valid=0; in_ready=1.
  - SHIFT: out_valid=1; busy=1.
- Input handshake: accept fires when in_valid && in_ready. On accept, word_q<=in_data, sel<=start value (0, or WIDTH-1 if MSB_FIRST), state<=SHIFT.
- Latency: first out_valid one cycle after accept. Registered state, no combinational in->out path.
- out_bit = word_q[out_sel] (combinational mux on registered data). out_sel = sel.
- out_last = SHIFT && (sel == end value), where end value is WIDTH-1, or 0 if MSB_FIRST.
- Output beat fires when out_valid && out_ready.
  - Non-last beat: sel steps by +1 (or -1 if MSB_FIRST).
  - Last beat: if no new word is accepted that cycle, state<=IDLE and sel returns to start value.
- Back-to-back: in_ready = IDLE || (SHIFT && out_ready && out_last), combinational from out_ready. If a word is accepted on the last-beat cycle, state stays SHIFT, word_q reloads, sel restarts. There are no bubbles between words.
- Backpressure: while out_valid && !out_ready, sel, word_q and out_bit hold stable. out_valid never drops without a beat.
- in_data is ignored whenever in_ready=0; word_q never changes mid-word.
- Reset mid-word: the word is discarded and outputs return to reset values immediately. No partial-word completion after reset release.
- Select counter wraps only via explicit reload; no modulo arithmetic is relied on beyond SEL_W bits.
- Exactly WIDTH beats per accepted word.

Decomposition:
- Shared package ser_pkg holds:
  - state enum {IDLE, SHIFT};
  - function clog2-based SEL_W derivation;
  - constants SEL_START/SEL_END computed from WIDTH and MSB_FIRST.
- One sub-module is natural: mux_nx1 (parameter N=WIDTH; inputs in[N], sel[SEL_W]; output y). It is instantiated for out_bit. The remaining counter, FSM and handshake logic stay in the top.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> outputs take reset values without waiting for clk; in_ready=1, out_valid=0, out_sel=0.
- Basic LSB-first: WIDTH=8, in_data=8'b10101111, out_ready held 1 -> over 8 beats out_sel=0..7, out_bit=1,1,1,1,0,1,0,1, out_last only on sel=7, then IDLE.
- MSB-first: MSB_FIRST=1, in_data=8'hA5 -> out_sel=7..0, out_bit=1,0,1,0,0,1,0,1; out_last on sel=0.
- Backpressure: in_data=8'h3C, toggle out_ready 1,0,0,1,... -> sel/out_bit hold during stalls; 8 beats total; no bit lost or duplicated.
- Back-to-back: present 8'hFF then 8'h00 with in_valid held -> second word accepted on the last-beat cycle of the first; 16 consecutive out_valid cycles; out_bit = eight 1s then eight 0s.
- Reset mid-word: in_data=8'hF0, assert rst after 3 beats -> out_valid=0 immediately. After release a new word 8'h0F serializes from sel=0.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the PISO serializer slice.
//   state_t    : serializer FSM states
//   sel_width  : select-code width for a given word width
//   sel_start  : first bit index emitted for a word
//   sel_end    : last bit index emitted for a word
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int sel_width(input int width);
    return $clog2(width);
  endfunction

  function automatic int sel_start(input int width, input bit msb_first);
    return msb_first ? width - 1 : 0;
  endfunction

  function automatic int sel_end(input int width, input bit msb_first);
    return msb_first ? 0 : width - 1;
  endfunction

endpackage

// File: rtl/mux_nx1.sv
// N:1 bit-select multiplexer.
//   in  : N candidate bits
//   sel : index of the bit to pass through
//   y   : in[sel]
module mux_nx1 #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     in,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);

  assign y = in[sel];

endmodule

// File: rtl/piso_mux_serializer.sv
// Parallel-in, serial-out serializer driving a WIDTH:1 bit-select mux.
//   clk, rst            : rising-edge clock, async active-high reset
//   in_valid/in_ready   : word handshake, in_data captured on accept
//   out_valid/out_ready : bit handshake, one bit per beat
//   out_bit             : word_q[out_sel]
//   out_sel             : current select code
//   out_last            : current beat is the final bit of the word
//   busy                : word in progress (SHIFT)
//
//   state | meaning
//   IDLE  | no word held, ready for a new word
//   SHIFT | walking word_q one bit per output beat
module piso_mux_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_W     = sel_width(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_last,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_START = SEL_W'(sel_start(WIDTH, MSB_FIRST));
  localparam logic [SEL_W-1:0] SEL_END   = SEL_W'(sel_end(WIDTH, MSB_FIRST));
  localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               accept, beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= SEL_START;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT);
  assign out_last  = (state_q == SHIFT) && (sel_q == SEL_END);
  // A new word may land on the final beat so consecutive words have no gap.
  assign in_ready  = (state_q == IDLE) || (out_ready && out_last);
  assign out_sel   = sel_q;
  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    if (accept) begin
      word_d  = in_data;
      sel_d   = SEL_START;
      state_d = SHIFT;
    end else if (beat) begin
      if (out_last) begin
        state_d = IDLE;
        sel_d   = SEL_START;
      end else if (MSB_FIRST) begin
        sel_d = sel_q - SEL_ONE;
      end else begin
        sel_d = sel_q + SEL_ONE;
      end
    end
  end

  mux_nx1 #(
    .N     (WIDTH),
    .SEL_W (SEL_W)
  ) u_mux (
    .in  (word_q),
    .sel (sel_q),
    .y   (out_bit)
  );

endmodule

// File: tb/tb_piso_mux_serializer.sv
module tb_piso_mux_serializer;

  localparam int W = 8;

  typedef struct packed {
    logic       b;
    logic [2:0] s;
    logic       l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         rdy_l, ov_l, ob_l, ol_l, bz_l;
  logic [2:0]   os_l;
  logic         rdy_m, ov_m, ob_m, ol_m, bz_m;
  logic [2:0]   os_m;

  int n_checks = 0;
  int n_fail   = 0;
  int rmode    = 0;   // 0: always ready, 1: random, 2: pattern 1,0,0,1
  int pat_idx  = 0;

  beat_t ql[$];
  beat_t qm[$];

  always #5 clk = ~clk;

  piso_mux_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data),
    .out_valid(ov_l), .out_ready(out_ready), .out_bit(ob_l), .out_sel(os_l),
    .out_last(ol_l), .busy(bz_l)
  );

  piso_mux_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data),
    .out_valid(ov_m), .out_ready(out_ready), .out_bit(ob_m), .out_sel(os_m),
    .out_last(ol_m), .busy(bz_m)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare one DUT against the front of its expected-beat list.
  task automatic cmp_dut(input string tag, input int qsz, input beat_t f,
                         input logic rdy, input logic ov, input logic ob,
                         input logic [2:0] os, input logic ol, input logic bz);
    logic exp_rdy;
    exp_rdy = (qsz == 0) || (out_ready && qsz == 1);
    chk({tag, ".in_ready"}, {31'd0, rdy}, {31'd0, exp_rdy});
    chk({tag, ".out_valid"}, {31'd0, ov}, {31'd0, qsz != 0});
    chk({tag, ".busy"}, {31'd0, bz}, {31'd0, qsz != 0});
    if (qsz != 0 && ov) begin
      chk({tag, ".out_bit"}, {31'd0, ob}, {31'd0, f.b});
      chk({tag, ".out_sel"}, {29'd0, os}, {29'd0, f.s});
      chk({tag, ".out_last"}, {31'd0, ol}, {31'd0, f.l});
    end
  endtask

  // Monitor/scoreboard: compare presented beat, retire it on handshake,
  // then expand any accepted word into its expected beat sequence.
  always @(negedge clk) begin
    if (!rst) begin
      beat_t fl, fm;
      bit acc;
      logic [W-1:0] d;
      fl = (ql.size() != 0) ? ql[0] : '0;
      fm = (qm.size() != 0) ? qm[0] : '0;
      acc = in_valid && rdy_l;
      d = in_data;
      cmp_dut("lsb", ql.size(), fl, rdy_l, ov_l, ob_l, os_l, ol_l, bz_l);
      cmp_dut("msb", qm.size(), fm, rdy_m, ov_m, ob_m, os_m, ol_m, bz_m);
      if (ov_l && out_ready && ql.size() != 0) void'(ql.pop_front());
      if (ov_m && out_ready && qm.size() != 0) void'(qm.pop_front());
      if (acc) begin
        for (int k = 0; k < W; k++) begin
          beat_t e;
          e.b = d[k];
          e.s = 3'(k);
          e.l = (k == W - 1);
          ql.push_back(e);
          e.b = d[W-1-k];
          e.s = 3'(W - 1 - k);
          qm.push_back(e);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        out_ready = (pat_idx % 3 == 0);
        pat_idx++;
      end
    endcase
  end

  // Called in the posedge+1 phase; returns in the posedge+1 phase after accept.
  task automatic send_word(input logic [W-1:0] d, input bit hold);
    int budget;
    bit acc;
    budget = 300;
    acc = 1'b0;
    in_data = d;
    in_valid = 1'b1;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = rdy_l;
      @(posedge clk);
      #1;
      budget--;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 for word %0h", d);
    end
    if (!hold) begin
      in_valid = 1'b0;
      in_data = W'($urandom);
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 300;
    while ((ql.size() != 0 || qm.size() != 0) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", ql.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    #12;
    chk("rst.in_ready", {31'd0, rdy_l}, 32'd1);
    chk("rst.out_valid", {31'd0, ov_l}, 32'd0);
    chk("rst.out_sel_lsb", {29'd0, os_l}, 32'd0);
    chk("rst.out_sel_msb", {29'd0, os_m}, 32'd7);
    chk("rst.out_last", {31'd0, ol_l | ol_m}, 32'd0);
    chk("rst.busy", {31'd0, bz_l | bz_m}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    rmode = 0;
    send_word(8'b1010_1111, 1'b0);
    wait_idle();
    send_word(8'hA5, 1'b0);
    wait_idle();

    rmode = 2;
    send_word(8'h3C, 1'b0);
    wait_idle();

    rmode = 0;
    send_word(8'hFF, 1'b1);
    send_word(8'h00, 1'b0);
    wait_idle();

    // Reset in the middle of a word.
    send_word(8'hF0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    ql.delete();
    qm.delete();
    #1;
    chk("midrst.out_valid", {31'd0, ov_l | ov_m}, 32'd0);
    chk("midrst.in_ready", {31'd0, rdy_l & rdy_m}, 32'd1);
    chk("midrst.out_sel_lsb", {29'd0, os_l}, 32'd0);
    chk("midrst.out_sel_msb", {29'd0, os_m}, 32'd7);
    chk("midrst.busy", {31'd0, bz_l | bz_m}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_word(8'h0F, 1'b0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      rmode = $urandom_range(0, 2);
      send_word(W'($urandom), $urandom_range(0, 1) == 1);
      if (!in_valid) begin
        repeat ($urandom_range(0, 4)) begin
          in_data = W'($urandom);
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
